// File: rtl/ha_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : ha_response_checker
// Brief    : On-chip stimulus/response checker for a half adder. Drives the
//            vectors 00,01,10,11, samples carry/sum on the last hold cycle of
//            each vector, and reports an error count, first failing vector
//            and a pass flag. Define HA_CHK_LOOP_EN for free-running mode.
// Revision : 1.0 - initial release
// ============================================================================
module ha_response_checker #(
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             c_in,
    input  logic             o_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [1:0]       fail_idx
);

    localparam logic [1:0]       c_st_idle   = 2'd0;
    localparam logic [1:0]       c_st_drive  = 2'd1;
    localparam logic [1:0]       c_st_done   = 2'd2;
    localparam logic [7:0]       c_hold_last = 8'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] c_err_max   = {ERR_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_vec_idx;
    logic [7:0]       r_hold_cnt;
    logic             r_a;
    logic             r_b;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_fail_valid;
    logic [1:0]       r_fail_idx;

    logic             w_launch;
    logic             w_last_hold;
    logic             w_finish;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_nxt;
    logic             w_fail_valid_nxt;
    logic [1:0]       w_fail_idx_nxt;

    // In loop mode the single DONE cycle itself relaunches the sequence.
`ifdef HA_CHK_LOOP_EN
    assign w_launch = ((r_state == c_st_idle) && start) || (r_state == c_st_done);
`else
    assign w_launch = start && ((r_state == c_st_idle) || (r_state == c_st_done));
`endif

    assign w_last_hold = (r_state == c_st_drive) && (r_hold_cnt == c_hold_last);
    assign w_finish    = w_last_hold && (r_vec_idx == 2'd3);
    assign w_mismatch  = w_last_hold && ({c_in, o_in} != {r_a & r_b, r_a ^ r_b});

    assign w_err_nxt        = (w_mismatch && (r_err_cnt != c_err_max)) ? r_err_cnt + ERR_W'(1)
                                                                       : r_err_cnt;
    assign w_fail_valid_nxt = r_fail_valid | w_mismatch;
    assign w_fail_idx_nxt   = (w_mismatch && !r_fail_valid) ? r_vec_idx : r_fail_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_drive;
                end
            end
            c_st_drive: begin
                if (w_finish) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
`ifdef HA_CHK_LOOP_EN
                w_state_nxt = c_st_drive;
`else
                if (start) begin
                    w_state_nxt = c_st_drive;
                end
`endif
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        busy = (r_state == c_st_drive);
        done = (r_state == c_st_done);
        pass = done && (err_count == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_vec_idx    <= 2'd0;
            r_hold_cnt   <= 8'd0;
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= 2'd0;
        end else if (w_launch) begin
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_vec_idx    <= 2'd0;
            r_hold_cnt   <= 8'd0;
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= 2'd0;
        end else if (r_state == c_st_drive) begin
            r_err_cnt    <= w_err_nxt;
            r_fail_valid <= w_fail_valid_nxt;
            r_fail_idx   <= w_fail_idx_nxt;
            if (w_last_hold) begin
                r_hold_cnt <= 8'd0;
                if (r_vec_idx == 2'd3) begin
                    r_a <= 1'b0;
                    r_b <= 1'b0;
                end else begin
                    r_vec_idx  <= r_vec_idx + 2'd1;
                    {r_a, r_b} <= r_vec_idx + 2'd1;
                end
            end else begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    assign a_out = r_a;
    assign b_out = r_b;

`ifdef HA_CHK_LOOP_EN
    logic [ERR_W-1:0] r_err_out;
    logic             r_fail_valid_out;
    logic [1:0]       r_fail_idx_out;

    // Published results change only on the done pulse, including the last compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_out        <= '0;
            r_fail_valid_out <= 1'b0;
            r_fail_idx_out   <= 2'd0;
        end else if (w_finish) begin
            r_err_out        <= w_err_nxt;
            r_fail_valid_out <= w_fail_valid_nxt;
            r_fail_idx_out   <= w_fail_idx_nxt;
        end
    end

    assign err_count  = r_err_out;
    assign fail_valid = r_fail_valid_out;
    assign fail_idx   = r_fail_idx_out;
`else
    assign err_count  = r_err_cnt;
    assign fail_valid = r_fail_valid;
    assign fail_idx   = r_fail_idx;
`endif

endmodule
`default_nettype wire
